hd_dma_ctrl: RTL and testbench

- Hardware sequencer that block-copies consecutive HD sectors into main memory or the file table, replacing the BIOS software copy loop (HD read, increment, compare, branch).
- Sits between the control unit and the HD / data-memory / file-table write ports; the CPU raises `start` with a job descriptor and stalls on `busy` until `done`.
- Handles one job at a time; sector overflow rolls onto the next track.

---
 rtl/hd_dma_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hd_dma_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/hd_dma_ctrl.sv
// ----------------------------------------------------------------------------
// hd_dma_ctrl
// Block-copy sequencer: reads consecutive HD sectors and writes each word to
// main memory or the file table, one word per REQ/WRITE pair.
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-low reset
//   start, dst_sel,       job request and descriptor (sampled in IDLE only)
//   src_trk, src_sect,
//   dst_addr, count
//   busy, done, err       job status (err = HD ack timeout, sticky to next job)
//   hd_req, hd_trk,       HD read request and sector address
//   hd_sect, hd_ack,
//   hd_data
//   mem_we, tab_we,       destination write strobes with shared address/data
//   wr_addr, wr_data
// ----------------------------------------------------------------------------
module hd_dma_ctrl #(
    parameter int DATA_W       = 32,
    parameter int ADDR_W       = 16,
    parameter int SECT_W       = 12,
    parameter int TRK_W        = 5,
    parameter int SECT_PER_TRK = 3000,
    parameter int CNT_W        = 16,
    parameter int TIMEOUT      = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              dst_sel,
    input  logic [TRK_W-1:0]  src_trk,
    input  logic [SECT_W-1:0] src_sect,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [CNT_W-1:0]  count,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              hd_req,
    output logic [TRK_W-1:0]  hd_trk,
    output logic [SECT_W-1:0] hd_sect,
    input  logic              hd_ack,
    input  logic [DATA_W-1:0] hd_data,
    output logic              mem_we,
    output logic              tab_we,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, REQ, WRITE, DONE} state_t;

    state_t             state;
    logic               sel;
    logic [CNT_W-1:0]   remain;
    logic [WAIT_W-1:0]  wait_cnt;
    logic [TRK_W-1:0]   trk_ptr;
    logic [SECT_W-1:0]  sect_ptr;
    logic [ADDR_W-1:0]  addr_ptr;

    // The pointer registers are the address outputs: during REQ they name the
    // sector being fetched, during WRITE the destination being written. They
    // advance at the end of WRITE.
    assign hd_trk  = trk_ptr;
    assign hd_sect = sect_ptr;
    assign wr_addr = addr_ptr;

    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            sel      <= 1'b0;
            remain   <= '0;
            wait_cnt <= '0;
            trk_ptr  <= '0;
            sect_ptr <= '0;
            addr_ptr <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            hd_req   <= 1'b0;
            mem_we   <= 1'b0;
            tab_we   <= 1'b0;
            wr_data  <= '0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            done   <= 1'b0;
            mem_we <= 1'b0;
            tab_we <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        sel      <= dst_sel;
                        remain   <= count;
                        trk_ptr  <= src_trk;
                        sect_ptr <= src_sect;
                        addr_ptr <= dst_addr;
                        wait_cnt <= '0;
                        err      <= 1'b0;
                        if (count == '0) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            busy   <= 1'b1;
                            hd_req <= 1'b1;
                            state  <= REQ;
                        end
                    end
                end

                REQ: begin
                    if (hd_ack) begin
                        wr_data  <= hd_data;
                        wait_cnt <= '0;
                        hd_req   <= 1'b0;
                        mem_we   <= ~sel;
                        tab_we   <= sel;
                        state    <= WRITE;
                    end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
                        // This is the TIMEOUT-th cycle without an ack: abort the
                        // job without writing the pending word.
                        wait_cnt <= '0;
                        err      <= 1'b1;
                        hd_req   <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt + WAIT_W'(1);
                    end
                end

                WRITE: begin
                    addr_ptr <= addr_ptr + ADDR_W'(1);
                    if (sect_ptr == SECT_W'(SECT_PER_TRK - 1)) begin
                        sect_ptr <= '0;
                        trk_ptr  <= trk_ptr + TRK_W'(1);
                    end else begin
                        sect_ptr <= sect_ptr + SECT_W'(1);
                    end
                    remain <= remain - CNT_W'(1);
                    if (remain == CNT_W'(1)) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        hd_req <= 1'b1;
                        state  <= REQ;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hd_dma_ctrl.sv
// ----------------------------------------------------------------------------
// tb_hd_dma_ctrl
// Directed bench for hd_dma_ctrl. Jobs come from a table of descriptors with
// hand-computed completion cycle, write/request counts, error flag and final
// HD pointer; a small pointer model checks every write address/data and every
// requested sector. A hand-written sequence covers reset in the middle of a job.
// ----------------------------------------------------------------------------
module tb_hd_dma_ctrl;

    logic        clock;
    logic        reset;
    logic        start;
    logic        dst_sel;
    logic [4:0]  src_trk;
    logic [11:0] src_sect;
    logic [15:0] dst_addr;
    logic [15:0] count;
    logic        busy;
    logic        done;
    logic        err;
    logic        hd_req;
    logic [4:0]  hd_trk;
    logic [11:0] hd_sect;
    logic        hd_ack;
    logic [31:0] hd_data;
    logic        mem_we;
    logic        tab_we;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;

    int checks = 0;
    int errors = 0;
    int ack_dly = 0;
    int req_cnt = 0;

    hd_dma_ctrl dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .dst_sel (dst_sel),
        .src_trk (src_trk),
        .src_sect(src_sect),
        .dst_addr(dst_addr),
        .count   (count),
        .busy    (busy),
        .done    (done),
        .err     (err),
        .hd_req  (hd_req),
        .hd_trk  (hd_trk),
        .hd_sect (hd_sect),
        .hd_ack  (hd_ack),
        .hd_data (hd_data),
        .mem_we  (mem_we),
        .tab_we  (tab_we),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // HD model: ack_dly == 0 holds ack high permanently (it must be ignored
    // outside REQ); otherwise ack rises on the (ack_dly+1)-th cycle of a
    // request. Data encodes the requested track/sector.
    always @(negedge clock) begin
        if (hd_req) req_cnt = req_cnt + 1;
        else        req_cnt = 0;
        hd_ack  = (ack_dly == 0) ? 1'b1 : (hd_req && (req_cnt >= ack_dly + 1));
        hd_data = {hd_trk, hd_sect, 15'h2A5A};
    end

    typedef struct {
        int cnt; int trk; int sect; int addr; int sel; int dly; int restart;
        int exp_done; int exp_wr; int exp_req; int exp_err; int end_trk; int end_sect;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic run_job(input vec_t v, input int idx);
        int k, nwr, nreq, dcyc, busy_bad, extra;
        logic [4:0]  et;
        logic [11:0] es;
        logic [15:0] ea;
        et = 5'(v.trk); es = 12'(v.sect); ea = 16'(v.addr);
        nwr = 0; nreq = 0; dcyc = -1; busy_bad = 0; extra = 0;

        @(negedge clock);
        dst_sel = v.sel[0]; src_trk = 5'(v.trk); src_sect = 12'(v.sect);
        dst_addr = 16'(v.addr); count = 16'(v.cnt); ack_dly = v.dly;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        // Descriptor changes after acceptance must not affect the job.
        dst_sel = ~v.sel[0]; src_trk = 5'h1F; src_sect = 12'd77; dst_addr = 16'h5555; count = 16'd7;
        k = 1;
        while (k < 1000 && dcyc < 0) begin
            if (v.restart != 0 && k == 3) start = 1'b0;
            if (hd_req) begin
                nreq++;
                chk($sformatf("v%0d_hd_trk", idx), 64'(hd_trk), 64'(et));
                chk($sformatf("v%0d_hd_sect", idx), 64'(hd_sect), 64'(es));
            end
            if (mem_we || tab_we) begin
                chk($sformatf("v%0d_mem_we", idx), 64'(mem_we), 64'(v.sel == 0));
                chk($sformatf("v%0d_tab_we", idx), 64'(tab_we), 64'(v.sel != 0));
                chk($sformatf("v%0d_wr_addr", idx), 64'(wr_addr), 64'(ea));
                chk($sformatf("v%0d_wr_data", idx), 64'(wr_data), 64'({et, es, 15'h2A5A}));
                nwr++;
                ea = ea + 16'd1;
                if (es == 12'd2999) begin es = 12'd0; et = et + 5'd1; end
                else es = es + 12'd1;
            end
            if (done) begin
                dcyc = k;
                chk($sformatf("v%0d_busy_at_done", idx), 64'(busy), 64'd0);
            end else if (!busy) begin
                busy_bad++;
            end
            // Start pulses while busy and in the DONE cycle must be dropped.
            if (v.restart != 0 && (k == 2 || dcyc >= 0)) begin
                count = 16'd5; start = 1'b1;
            end
            @(negedge clock);
            k++;
        end
        start = 1'b0;
        if (dcyc < 0) $display("FAIL v%0d_timeout no done within budget", idx);
        chk($sformatf("v%0d_done_cycle", idx), 64'(dcyc), 64'(v.exp_done));
        chk($sformatf("v%0d_writes", idx), 64'(nwr), 64'(v.exp_wr));
        chk($sformatf("v%0d_req_cycles", idx), 64'(nreq), 64'(v.exp_req));
        chk($sformatf("v%0d_busy_low", idx), 64'(busy_bad), 64'(v.exp_done > 1 ? 0 : busy_bad));
        chk($sformatf("v%0d_end_trk", idx), 64'(hd_trk), 64'(v.end_trk));
        chk($sformatf("v%0d_end_sect", idx), 64'(hd_sect), 64'(v.end_sect));
        // Idle window: no further activity, err held.
        for (int i = 0; i < 3; i++) begin
            if (done || hd_req || mem_we || tab_we || busy) extra++;
            chk($sformatf("v%0d_err_hold", idx), 64'(err), 64'(v.exp_err));
            @(negedge clock);
        end
        chk($sformatf("v%0d_idle_activity", idx), 64'(extra), 64'd0);
    endtask

    initial begin
        int nwr, k;
        //           cnt trk sect  addr   sel dly  rs done  wr  req err etrk esect
        vecs[0] = '{4,   1,  0,    0,     0,  0,   0, 9,   4,  4,  0,  1,   4};
        vecs[1] = '{3,   2,  2998, 100,   0,  0,   0, 7,   3,  3,  0,  3,   1};
        vecs[2] = '{80,  0,  0,    0,     1,  3,   0, 401, 80, 320,0,  0,   80};
        vecs[3] = '{2,   7,  5,    50,    0,  1000,0, 256, 0,  255,1,  7,   5};
        vecs[4] = '{0,   3,  3,    3,     0,  0,   0, 1,   0,  0,  0,  3,   3};
        vecs[5] = '{1,   4,  10,   200,   1,  0,   0, 3,   1,  1,  0,  4,   11};
        vecs[6] = '{3,   31, 2999, 65534, 0,  2,   1, 13,  3,  9,  0,  0,   2};

        reset = 1'b0; start = 1'b0; dst_sel = 1'b0; src_trk = '0; src_sect = '0;
        dst_addr = '0; count = '0;
        repeat (3) @(negedge clock);
        chk("reset_outputs", 64'({busy, done, err, hd_req, mem_we, tab_we}), 64'd0);
        chk("reset_ptrs", 64'({hd_trk, hd_sect, wr_addr}), 64'd0);
        chk("reset_wr_data", 64'(wr_data), 64'd0);
        reset = 1'b1;

        for (int i = 0; i < 5; i++) run_job(vecs[i], i);

        // Reset in the middle of a 10-word job, right after the 4th write.
        @(negedge clock);
        dst_sel = 1'b0; src_trk = 5'd0; src_sect = 12'd0; dst_addr = 16'd0;
        count = 16'd10; ack_dly = 0; start = 1'b1;
        @(negedge clock);
        start = 1'b0; nwr = 0; k = 0;
        while (nwr < 4 && k < 200) begin
            if (mem_we) nwr++;
            @(negedge clock);
            k++;
        end
        chk("rst_mid_writes_before", 64'(nwr), 64'd4);
        reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_status", 64'({busy, done, err, hd_req, mem_we, tab_we}), 64'd0);
        chk("rst_mid_ptrs", 64'({hd_trk, hd_sect, wr_addr}), 64'd0);
        chk("rst_mid_wr_data", 64'(wr_data), 64'd0);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_mid_stays_idle", 64'({busy, hd_req, mem_we}), 64'd0);

        run_job(vecs[5], 5);
        run_job(vecs[6], 6);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
